vga_sync_ctrl: RTL and testbench

Timing controller for the 640x480 @ 60 Hz VGA path. It generates the horizontal and vertical pixel counters `hc` and `vc`, active-low `hsync` and `vsync`, and the `vidon` blanking qualifier consumed by the pattern generators. It also supplies a pixel strobe, a start-of-frame pulse and a free-running frame counter so that pattern blocks can animate. It sits between the board clock and every pixel-colour generator in the VGA design.

---
 rtl/vga_sync_ctrl.sv | 138 +++++++++++++
 tb/tb_vga_sync_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_ctrl
//  Purpose  : 640x480 @ 60 Hz VGA timing controller. Generates the pixel
//             strobe, horizontal/vertical pixel counters, active-low syncs,
//             the visible-window qualifier, a start-of-frame pulse and a
//             free-running frame counter for animated pattern generators.
//  Ports    : clk         in   board clock (single domain)
//             clr         in   asynchronous active-high reset
//             pix_en      out  pixel strobe; counters advance only when 1
//             hc          out  horizontal count 0..H_TOT-1
//             vc          out  vertical count 0..V_TOT-1
//             hsync       out  active-low horizontal sync
//             vsync       out  active-low vertical sync
//             vidon       out  1 inside the visible window, 0 during clr
//             frame_start out  one-clk pulse at the first pixel of a frame
//             frame_cnt   out  frames completed since reset, wraps at 256
//  Options  : VGA_PIXDIV_EN  defined   -> clk is 2x the pixel rate; an
//                                         internal toggle divides it down
//                            undefined -> clk is the pixel clock
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_ctrl #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       clk,
  input  logic       clr,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  // Timing boundaries, all as unsigned 10-bit values to match the counters.
  localparam logic [9:0] c_H_VIS  = 10'(H_VIS);
  localparam logic [9:0] c_HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_VIS  = 10'(V_VIS);
  localparam logic [9:0] c_VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_VS_END = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] c_V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic [7:0] r_frame_cnt;
  logic       r_frame_start;
  logic       w_pix_en;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_frame_wrap;

  // --------------------------------------------------------------------------
  // Pixel strobe
  // --------------------------------------------------------------------------
`ifdef VGA_PIXDIV_EN
  // Toggle flop: goes high on the first edge after release, so the first
  // counted strobe is sampled on the second edge.
  logic r_div;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  assign w_pix_en = r_div;
`else
  // clk already runs at the pixel rate; only reset suppresses counting.
  assign w_pix_en = ~clr;
`endif

  // --------------------------------------------------------------------------
  // Counters and frame bookkeeping
  // --------------------------------------------------------------------------
  assign w_h_wrap     = (r_hc == c_H_LAST);
  assign w_v_wrap     = (r_vc == c_V_LAST);
  assign w_frame_wrap = w_h_wrap & w_v_wrap;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_frame_cnt   <= 8'd0;
      r_frame_start <= 1'b0;
    end else if (w_pix_en) begin
      if (w_h_wrap) begin
        r_hc <= 10'd0;
        if (w_v_wrap) begin
          r_vc <= 10'd0;
        end else begin
          r_vc <= r_vc + 10'd1;
        end
      end else begin
        r_hc <= r_hc + 10'd1;
      end
      // Registered on the wrap strobe so the pulse lines up with the first
      // cycle showing hc=0, vc=0. The state right after reset never wrapped,
      // so no pulse is produced for the first frame.
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      // Clearing on idle cycles keeps the pulse one clk wide even when the
      // strobe runs slower than clk.
      r_frame_start <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decodes (combinational, aligned with the registered counters)
  // --------------------------------------------------------------------------
  assign pix_en      = w_pix_en;
  assign hc          = r_hc;
  assign vc          = r_vc;
  assign frame_cnt   = r_frame_cnt;
  assign frame_start = r_frame_start;
  assign hsync       = ~((r_hc >= c_HS_BEG) && (r_hc < c_HS_END));
  assign vsync       = ~((r_vc >= c_VS_BEG) && (r_vc < c_VS_END));
  // clr is folded in so pattern blocks emit black while reset is held.
  assign vidon       = (r_hc < c_H_VIS) && (r_vc < c_V_VIS) && ~clr;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_ctrl
//  Purpose  : Self-checking bench for vga_sync_ctrl. One instance uses the
//             real 640x480 timing for line-level checks; a second instance
//             with a tiny 16x11 raster makes frame-level events reachable.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_ctrl;

  logic       clk;
  logic       clr;

  logic       b_pix_en, b_hsync, b_vsync, b_vidon, b_fs;
  logic [9:0] b_hc, b_vc;
  logic [7:0] b_fcnt;

  logic       s_pix_en, s_hsync, s_vsync, s_vidon, s_fs;
  logic [9:0] s_hc, s_vc;
  logic [7:0] s_fcnt;

  vga_sync_ctrl dut_b (
    .clk(clk), .clr(clr), .pix_en(b_pix_en), .hc(b_hc), .vc(b_vc),
    .hsync(b_hsync), .vsync(b_vsync), .vidon(b_vidon),
    .frame_start(b_fs), .frame_cnt(b_fcnt)
  );

  // Small raster: H_TOT=16 (hsync low hc 10..12), V_TOT=11 (vsync low vc 7..8),
  // visible 8x6, frame = 176 strobes.
  vga_sync_ctrl #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .clr(clr), .pix_en(s_pix_en), .hc(s_hc), .vc(s_vc),
    .hsync(s_hsync), .vsync(s_vsync), .vidon(s_vidon),
    .frame_start(s_fs), .frame_cnt(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k_now = 0;

  // window statistics gathered while walking the vector table
  int b_hs_low = 0, b_vid_hi = 0;
  int s_vs_low = 0, s_vid_hi = 0, s_fs_early = 0, s_fs_total = 0;

  typedef struct {
    int k;      // strobes since release
    bit sel;    // 0 = full-size instance, 1 = small instance
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit vid;
    bit fs;
    int fcnt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", nm, act, exp, k_now);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k_now++;
  endtask

  // step plus window bookkeeping; every frame_start pulse must sit on 0/0
  task automatic advance();
    step();
    if (k_now <= 800) begin
      if (!b_hsync) b_hs_low++;
      if (b_vidon)  b_vid_hi++;
    end
    if (k_now <= 176) begin
      if (!s_vsync) s_vs_low++;
      if (s_vidon)  s_vid_hi++;
    end
    if (s_fs) begin
      s_fs_total++;
      if (k_now <= 527) s_fs_early++;
      chk("fs_pos_hc", int'(s_hc), 0);
      chk("fs_pos_vc", int'(s_vc), 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_b_hc"},   int'(b_hc), 0);
    chk({tag, "_b_vc"},   int'(b_vc), 0);
    chk({tag, "_b_hs"},   int'(b_hsync), 1);
    chk({tag, "_b_vs"},   int'(b_vsync), 1);
    chk({tag, "_b_vid"},  int'(b_vidon), 0);
    chk({tag, "_b_fs"},   int'(b_fs), 0);
    chk({tag, "_b_fcnt"}, int'(b_fcnt), 0);
    chk({tag, "_b_pix"},  int'(b_pix_en), 0);
    chk({tag, "_s_hc"},   int'(s_hc), 0);
    chk({tag, "_s_vc"},   int'(s_vc), 0);
    chk({tag, "_s_fcnt"}, int'(s_fcnt), 0);
    chk({tag, "_s_vid"},  int'(s_vidon), 0);
  endtask

  initial begin
    //        k     sel   hc   vc  hs  vs  vid fs fcnt
    tbl[0]  = '{1,    0,   1,   0, 1, 1, 1, 0, 0};
    tbl[1]  = '{7,    1,   7,   0, 1, 1, 1, 0, 0};
    tbl[2]  = '{8,    1,   8,   0, 1, 1, 0, 0, 0};
    tbl[3]  = '{10,   1,  10,   0, 0, 1, 0, 0, 0};
    tbl[4]  = '{13,   1,  13,   0, 1, 1, 0, 0, 0};
    tbl[5]  = '{16,   1,   0,   1, 1, 1, 1, 0, 0};
    tbl[6]  = '{96,   1,   0,   6, 1, 1, 0, 0, 0};
    tbl[7]  = '{112,  1,   0,   7, 1, 0, 0, 0, 0};
    tbl[8]  = '{143,  1,  15,   8, 1, 0, 0, 0, 0};
    tbl[9]  = '{144,  1,   0,   9, 1, 1, 0, 0, 0};
    tbl[10] = '{175,  1,  15,  10, 1, 1, 0, 0, 0};
    tbl[11] = '{176,  1,   0,   0, 1, 1, 1, 1, 1};
    tbl[12] = '{527,  1,  15,  10, 1, 1, 0, 0, 2};
    tbl[13] = '{639,  0, 639,   0, 1, 1, 1, 0, 0};
    tbl[14] = '{640,  0, 640,   0, 1, 1, 0, 0, 0};
    tbl[15] = '{655,  0, 655,   0, 1, 1, 0, 0, 0};
    tbl[16] = '{656,  0, 656,   0, 0, 1, 0, 0, 0};
    tbl[17] = '{751,  0, 751,   0, 0, 1, 0, 0, 0};
    tbl[18] = '{752,  0, 752,   0, 1, 1, 0, 0, 0};
    tbl[19] = '{799,  0, 799,   0, 1, 1, 0, 0, 0};
    tbl[20] = '{800,  0,   0,   1, 1, 1, 1, 0, 0};
    tbl[21] = '{1456, 0, 656,   1, 0, 1, 0, 0, 0};
    tbl[22] = '{1600, 0,   0,   2, 1, 1, 1, 0, 0};

    // ---- reset hold ----
    clr = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset("rst");
    clr = 1'b0;
    #1;
    chk("rel_b_vid", int'(b_vidon), 1);
    chk("rel_b_pix", int'(b_pix_en), 1);
    chk("rel_b_hc",  int'(b_hc), 0);

    // ---- vector table ----
    for (int i = 0; i < NV; i++) begin
      while (k_now < tbl[i].k) advance();
      if (!tbl[i].sel) begin
        chk("v_hc",   int'(b_hc),    tbl[i].hc);
        chk("v_vc",   int'(b_vc),    tbl[i].vc);
        chk("v_hs",   int'(b_hsync), int'(tbl[i].hs));
        chk("v_vs",   int'(b_vsync), int'(tbl[i].vs));
        chk("v_vid",  int'(b_vidon), int'(tbl[i].vid));
        chk("v_fs",   int'(b_fs),    int'(tbl[i].fs));
        chk("v_fcnt", int'(b_fcnt),  tbl[i].fcnt);
      end else begin
        chk("vs_hc",   int'(s_hc),    tbl[i].hc);
        chk("vs_vc",   int'(s_vc),    tbl[i].vc);
        chk("vs_hs",   int'(s_hsync), int'(tbl[i].hs));
        chk("vs_vs",   int'(s_vsync), int'(tbl[i].vs));
        chk("vs_vid",  int'(s_vidon), int'(tbl[i].vid));
        chk("vs_fs",   int'(s_fs),    int'(tbl[i].fs));
        chk("vs_fcnt", int'(s_fcnt),  tbl[i].fcnt);
      end
    end
    chk("line_hsync_low", b_hs_low, 96);
    chk("line_vidon_hi",  b_vid_hi, 640);
    chk("frame_vsync_low", s_vs_low, 32);
    chk("frame_vidon_hi",  s_vid_hi, 48);
    chk("three_frames_fs", s_fs_early, 2);

    // ---- mid-frame asynchronous reset ----
    // k=1637: small is 9 frames + 53 strobes -> hc=5 vc=3 fcnt=9;
    // full-size is hc=37 vc=2.
    while (k_now < 1637) advance();
    chk("mid_s_hc",   int'(s_hc), 5);
    chk("mid_s_vc",   int'(s_vc), 3);
    chk("mid_s_fcnt", int'(s_fcnt), 9);
    chk("mid_b_hc",   int'(b_hc), 37);
    chk("mid_b_vc",   int'(b_vc), 2);
    clr = 1'b1;
    #1;                       // no clock edge has occurred yet
    chk_reset("async");
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("post_b_hc", int'(b_hc), 0);
    k_now = 0;
    s_fs_total = 0;
    step();
    chk("post_b_hc1", int'(b_hc), 1);
    chk("post_s_hc1", int'(s_hc), 1);
    chk("post_s_fs",  int'(s_fs), 0);

    // ---- frame_cnt wrap on the small instance ----
    while (k_now < 44880) advance();
    chk("w255_fcnt", int'(s_fcnt), 255);
    chk("w255_fs",   int'(s_fs), 1);
    while (k_now < 45055) advance();
    chk("wpre_fcnt", int'(s_fcnt), 255);
    chk("wpre_hc",   int'(s_hc), 15);
    chk("wpre_vc",   int'(s_vc), 10);
    advance();
    chk("wrap_fcnt", int'(s_fcnt), 0);
    chk("wrap_fs",   int'(s_fs), 1);
    chk("wrap_hc",   int'(s_hc), 0);
    chk("wrap_vc",   int'(s_vc), 0);
    chk("wrap_b_hc", int'(b_hc), 256);
    chk("wrap_b_vc", int'(b_vc), 56);
    advance();
    chk("wpost_fs",   int'(s_fs), 0);
    chk("wpost_hc",   int'(s_hc), 1);
    chk("wpost_fcnt", int'(s_fcnt), 0);
    chk("fs_total",   s_fs_total, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
